// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Stall merge, redirect flush sequencing and stall watchdog for
//             the 5-stage pipeline.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    FLUSH_CYCLES = 1,
  parameter int                    MAX_STALL    = 64,
  parameter logic [ADDR_WIDTH-1:0] TIMEOUT_PC   = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  stallreq_mem,
  input  logic                  flush_req,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] new_pc,
  output logic                  new_pc_valid,
  output logic                  stall_timeout
);

  localparam int CNT_W  = $clog2(MAX_STALL + 1);
  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_STALL - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_STALL);
  localparam logic [FCNT_W-1:0] FCNT_LOAD  = FCNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [FCNT_W-1:0]       fcnt_q;
  logic                    flush_q;
  logic [ADDR_WIDTH-1:0]   new_pc_q;
  logic                    new_pc_valid_q;
  logic                    stall_timeout_q;

  logic                    stall_any;
  logic                    wd_fire;

  // Deepest requester wins: a hold in a later stage freezes everything upstream.
  always_comb begin
    stall = 6'b000000;
    if (rst_n && (state_q != ST_FLUSH)) begin
      if (stallreq_mem)      stall = 6'b011111;
      else if (stallreq_ex)  stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
    end
  end

  assign stall_any = |stall;
  assign wd_fire   = stall_any && (cnt_q == CNT_LAST);
  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      cnt_q           <= '0;
      fcnt_q          <= '0;
      flush_q         <= 1'b0;
      new_pc_q        <= '0;
      new_pc_valid_q  <= 1'b0;
      stall_timeout_q <= 1'b0;
    end else begin
      new_pc_valid_q  <= 1'b0;
      stall_timeout_q <= 1'b0;
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (flush_req) begin
            state_q        <= ST_FLUSH;
            flush_q        <= 1'b1;
            fcnt_q         <= FCNT_LOAD;
            cnt_q          <= '0;
            new_pc_q       <= flush_pc;
            new_pc_valid_q <= 1'b1;
          end else if (wd_fire) begin
            state_q         <= ST_FLUSH;
            flush_q         <= 1'b1;
            fcnt_q          <= FCNT_LOAD;
            cnt_q           <= '0;
            new_pc_q        <= TIMEOUT_PC;
            new_pc_valid_q  <= 1'b1;
            stall_timeout_q <= 1'b1;
          end else begin
            state_q <= stall_any ? ST_STALL : ST_RUN;
            cnt_q   <= stall_any ? cnt_d : '0;
          end
        end
        ST_FLUSH: begin
          // Requests arriving here are dropped, including on the exit edge.
          cnt_q <= '0;
          if (fcnt_q == '0) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign new_pc_valid  = new_pc_valid_q;
  assign stall_timeout = stall_timeout_q;

endmodule

`default_nettype wire
